if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage. Drives the instruction-memory request port, tracks the fetch PC and holds returned instructions in a small fetch queue.
- Owns the IF/ID pipeline register, which feeds the decode stage with `if_id_IR`, `if_id_PC` and `if_id_valid_inst`.
- Accepts a redirect from the branch/jump resolution logic and a stall from hazard control.
- Tolerates variable memory latency, with at most one request outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FQ_DEPTH, 2, fetch-queue entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  system reset, asynchronous, active-high.
- imem_req  out  1  single-cycle fetch request pulse; memory accepts unconditionally.
- imem_addr  out  32  fetch address (= fetch_pc); meaningful only while imem_req=1.
- imem_rvalid  in  1  response valid; ≥1 cycle after the matching imem_req.
- imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
- redirect_en  in  1  taken branch/jump: flush and refetch from redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored (forced to 0).
- stall  in  1  hold the IF/ID register (decode cannot accept).
- if_id_IR  out  32  registered instruction to decode.
- if_id_PC  out  32  registered PC of if_id_IR.
- if_id_valid_inst  out  1  if_id_IR is a real instruction (0 = bubble).

Behaviour:
- Reset (async, any state, including mid-request): fetch_pc=RESET_PC, FSM=REQ, queue empty, if_id_IR=32'h0000_0013 (NOP), if_id_PC=0, if_id_valid_inst=0. imem_req is 0 while rst=1.
- FSM states:
  - REQ: nothing outstanding.
  - WAIT: one request outstanding whose response is kept.
  - DROP: one request outstanding whose response is discarded.
- Occupancy rule: queue count + outstanding ≤ FQ_DEPTH at all times.
- Issue condition (combinational), imem_req=1 when all of:
  - rst=0 and redirect_en=0;
  - (FSM=REQ) or (FSM=WAIT and imem_rvalid=1);
  - count + wr − rd < FQ_DEPTH, where wr = FSM=WAIT & imem_rvalid, and rd = queue dequeue this cycle.
- On issue: record req_pc=fetch_pc; fetch_pc += 4 (mod 2^32, wraps from FFFF_FFFC to 0); next FSM=WAIT.
- Response handling:
  - WAIT & imem_rvalid: push {req_pc, imem_rdata}. Next FSM is WAIT if a request issued this cycle, else REQ.
  - DROP & imem_rvalid: discard the response; next FSM=REQ.
  - imem_rvalid in REQ: ignored (protocol violation, no state change).
- Queue: circular buffer with rd/wr pointers and count (0..FQ_DEPTH). Push and pop in the same cycle are legal at any count. It never overflows, because of the issue rule.
- IF/ID register, priority order:
  1. redirect_en=1: if_id_valid_inst←0; IR/PC hold. Redirect beats stall.
  2. stall=1: IR/PC/valid all hold.
  3. Queue non-empty: pop head; IR←inst, PC←pc, valid←1.
  4. Queue empty: valid←0 (bubble); IR/PC hold.
- Latency: no bypass from imem_rdata to IF/ID. With rvalid in cycle N, the instruction is visible on if_id outputs in cycle N+2 (queue was empty, no stall).
- Throughput: 1 instruction/cycle with 1-cycle memory and no stall.
- Redirect (redirect_en=1), same edge:
  - queue flushed (count=0);
  - fetch_pc←{redirect_pc[31:2],2'b00};
  - next FSM: WAIT→DROP if imem_rvalid=0; WAIT→REQ if imem_rvalid=1 (that response is discarded); REQ→REQ; DROP→DROP (→REQ if rvalid that cycle).
  - No request issues in the redirect cycle; the first request to the new PC goes out the next cycle in REQ, or after the DROP response.
- Back-to-back redirects: the last one wins; each flushes again.

Test Plan:
- Reset release, 1-cycle memory, RESET_PC=0x0, no stall → requests at 0x0,0x4,0x8 in consecutive cycles; if_id_PC 0x0,0x4,0x8 with valid=1 from cycle 3 onward, 1/cycle.
- stall=1 for 6 cycles mid-stream, FQ_DEPTH=2 → IF/ID held. At most 2 queued + 0 outstanding; imem_req stops. After release, sequence resumes without loss or duplication.
- 3-cycle memory latency → one request every 3 cycles; if_id_valid_inst pattern 1,0,0 repeating; PCs consecutive.
- redirect_en=1 to 0x100 while in WAIT (response arrives 2 cycles later with 0xDEAD_BEEF) → 0xDEAD_BEEF never reaches IF/ID; next imem_addr=0x100; first valid if_id_PC=0x100.
- redirect_en coincident with imem_rvalid and stall=1 → response dropped, valid←0 despite stall; next request to redirect_pc in the following cycle.
- Assert rst asynchronously in WAIT mid-cycle; stale rvalid arrives after release → outputs at reset values immediately; stale rvalid ignored (REQ); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues single-cycle fetch requests (at most one outstanding), buffers returned
// instructions in a small circular fetch queue and drives the IF/ID pipeline register.
// A redirect flushes the queue, retargets the fetch PC and discards any response that
// is still in flight; hazard-control stall holds the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    localparam int unsigned PtrW = $clog2(FQ_DEPTH);
    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);
    localparam logic [CntW:0] DepthOcc = FQ_DEPTH[CntW:0];
    localparam logic [31:0] Nop = 32'h0000_0013;

    // StWait: response will be kept; StDrop: response will be thrown away.
    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop
    } state_e;

    state_e state_q, state_d;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] fq_cnt_q, fq_cnt_d;
    logic [31:0]     fq_pc_q   [FQ_DEPTH];
    logic [31:0]     fq_inst_q [FQ_DEPTH];

    logic [31:0] if_id_ir_q, if_id_ir_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic          resp_keep;
    logic          fq_push;
    logic          fq_pop;
    logic [CntW:0] occ_after;
    logic          issue;

    // Queue handshake terms; occ_after is the queue count once this cycle's push/pop land.
    always_comb begin
        resp_keep = (state_q == StWait) && imem_rvalid;
        fq_push   = resp_keep && !redirect_en;
        fq_pop    = !redirect_en && !stall && (fq_cnt_q != '0);
        occ_after = {1'b0, fq_cnt_q} + {{CntW{1'b0}}, resp_keep}
                  - {{CntW{1'b0}}, fq_pop};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect overrides normal sequencing and never issues.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (issue) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_en) begin
                    // A response arriving in the redirect cycle is simply ignored.
                    state_d = imem_rvalid ? StReq : StDrop;
                end else if (imem_rvalid) begin
                    state_d = issue ? StWait : StReq;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // FSM output: issue only when the queue can absorb the new response.
    always_comb begin
        issue = 1'b0;
        if (!rst && !redirect_en) begin
            if ((state_q == StReq) || resp_keep) begin
                issue = (occ_after < DepthOcc);
            end
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    // Fetch PC and PC of the outstanding request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_en) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Queue pointer/count update; a redirect empties the queue outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fq_cnt_d = fq_cnt_q;
        if (redirect_en) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fq_cnt_d = '0;
        end else begin
            if (fq_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (fq_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (fq_push && !fq_pop) begin
                fq_cnt_d = fq_cnt_q + CntW'(1);
            end else if (!fq_push && fq_pop) begin
                fq_cnt_d = fq_cnt_q - CntW'(1);
            end
        end
    end

    // Queue control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fq_cnt_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fq_cnt_q <= fq_cnt_d;
        end
    end

    // Queue storage; contents are don't-care while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (fq_push) begin
            fq_pc_q[wr_ptr_q]   <= req_pc_q;
            fq_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // IF/ID next state: redirect > stall > pop head > bubble.
    always_comb begin
        if_id_ir_d    = if_id_ir_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect_en) begin
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            if_id_valid_d = if_id_valid_q;
        end else if (fq_cnt_q != '0) begin
            if_id_ir_d    = fq_inst_q[rd_ptr_q];
            if_id_pc_d    = fq_pc_q[rd_ptr_q];
            if_id_valid_d = 1'b1;
        end else begin
            if_id_valid_d = 1'b0;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_ir_q    <= Nop;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_ir_q    <= if_id_ir_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_IR         = if_id_ir_q;
    assign if_id_PC         = if_id_pc_q;
    assign if_id_valid_inst = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall back-pressure, slow memory,
// redirects (in WAIT and coincident with a response under stall) and async reset.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // Memory model state.
    logic        pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'h0;
    int          lat       = 1;
    logic        poison    = 1'b0;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .FQ_DEPTH(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .if_id_IR        (if_id_IR),
        .if_id_PC        (if_id_PC),
        .if_id_valid_inst(if_id_valid_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL c%0d %s: observed %h expected %h", cyc_n, tag, obs, exp);
        end
    endtask

    // Drive per-cycle controls, let logic settle, check outputs of this cycle.
    task automatic drive_check(input logic s, input logic r, input logic [31:0] rp,
                               input logic exp_req, input logic [31:0] exp_addr,
                               input logic exp_valid, input logic [31:0] exp_pc);
        stall       = s;
        redirect_en = r;
        redirect_pc = rp;
        #1;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        chk("if_id_valid_inst", 32'(if_id_valid_inst), 32'(exp_valid));
        chk("if_id_PC", if_id_PC, exp_pc);
        if (exp_valid) chk("if_id_IR", if_id_IR, mem_word(exp_pc));
    endtask

    // Capture this cycle's request, advance one clock, drive the memory response.
    task automatic next_cycle();
        #1;
        if (imem_req === 1'b1) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = imem_addr;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend        = 1'b0;
                imem_rvalid = 1'b1;
                imem_rdata  = poison ? 32'hDEAD_BEEF : mem_word(pend_addr);
                poison      = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] rp,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic exp_valid, input logic [31:0] exp_pc);
        drive_check(s, r, rp, exp_req, exp_addr, exp_valid, exp_pc);
        next_cycle();
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst imem_req", 32'(imem_req), 32'h0);
        chk("rst valid", 32'(if_id_valid_inst), 32'h0);
        chk("rst PC", if_id_PC, 32'h0);
        chk("rst IR", if_id_IR, 32'h0000_0013);

        // Streaming with 1-cycle memory.
        rst   = 1'b0;
        cyc_n = 0;
        cyc(0, 0, 0, 1, 32'h00, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h04, 0, 32'h0);
        chk("bubble IR", if_id_IR, 32'h0000_0013);
        cyc(0, 0, 0, 1, 32'h08, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h0C, 1, 32'h0);
        cyc(0, 0, 0, 1, 32'h10, 1, 32'h4);
        cyc(0, 0, 0, 1, 32'h14, 1, 32'h8);

        // Six stall cycles: queue fills to 2, requests stop, IF/ID holds.
        repeat (6) cyc(1, 0, 0, 0, 32'h0, 1, 32'hC);
        cyc(0, 0, 0, 1, 32'h18, 1, 32'hC);
        cyc(0, 0, 0, 1, 32'h1C, 1, 32'h10);
        cyc(0, 0, 0, 1, 32'h20, 1, 32'h14);
        cyc(0, 0, 0, 1, 32'h24, 1, 32'h18);

        // 3-cycle memory.
        lat = 3;
        cyc(0, 0, 0, 1, 32'h28, 1, 32'h1C);
        cyc(0, 0, 0, 0, 32'h0,  1, 32'h20);
        cyc(0, 0, 0, 0, 32'h0,  1, 32'h24);
        cyc(0, 0, 0, 1, 32'h2C, 0, 32'h24);
        cyc(0, 0, 0, 0, 32'h0,  0, 32'h24);
        cyc(0, 0, 0, 0, 32'h0,  1, 32'h28);
        cyc(0, 0, 0, 1, 32'h30, 0, 32'h28);
        cyc(0, 0, 0, 0, 32'h0,  0, 32'h28);
        cyc(0, 0, 0, 0, 32'h0,  1, 32'h2C);
        cyc(0, 0, 0, 1, 32'h34, 0, 32'h2C);

        // Redirect in WAIT; the in-flight response (DEADBEEF) must be dropped.
        poison = 1'b1;
        cyc(0, 1, 32'h100, 0, 32'h0, 0, 32'h2C);
        cyc(0, 0, 0, 0, 32'h0, 0, 32'h2C);
        cyc(0, 0, 0, 0, 32'h0, 0, 32'h2C);
        lat = 1;
        cyc(0, 0, 0, 1, 32'h100, 0, 32'h2C);
        cyc(0, 0, 0, 1, 32'h104, 0, 32'h2C);
        cyc(0, 0, 0, 1, 32'h108, 0, 32'h2C);

        // Redirect with response and stall in the same cycle; low PC bits ignored.
        cyc(1, 1, 32'h203, 0, 32'h0, 1, 32'h100);
        cyc(0, 0, 0, 1, 32'h200, 0, 32'h100);
        cyc(0, 0, 0, 1, 32'h204, 0, 32'h100);
        cyc(0, 0, 0, 1, 32'h208, 0, 32'h100);

        // Async reset mid-cycle while a slow request is outstanding.
        lat = 3;
        cyc(0, 0, 0, 1, 32'h20C, 1, 32'h200);
        drive_check(0, 0, 0, 0, 32'h0, 1, 32'h204);
        #1 rst = 1'b1;
        #1;
        chk("async valid", 32'(if_id_valid_inst), 32'h0);
        chk("async PC", if_id_PC, 32'h0);
        chk("async IR", if_id_IR, 32'h0000_0013);
        chk("async imem_req", 32'(imem_req), 32'h0);
        next_cycle();
        drive_check(0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("rst hold IR", if_id_IR, 32'h0000_0013);
        next_cycle();
        // Stale response arrives in the release cycle and must be ignored.
        rst = 1'b0;
        lat = 1;
        chk("stale rvalid present", 32'(imem_rvalid), 32'h1);
        cyc(0, 0, 0, 1, 32'h00, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h04, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h08, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h0C, 1, 32'h0);
        cyc(0, 0, 0, 1, 32'h10, 1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
